// File: rtl/sw_stim_pkg.sv
// Shared types and field constants for the switch-input stimulus driver.
package sw_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESENT = 3'd1,
    ST_RELEASE = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAIL    = 3'd4
  } sw_stim_state_e;

  localparam int SW_VALID_BIT = 31;
  localparam int SW_TAG_MSB   = 30;
  localparam int SW_TAG_LSB   = 24;
  localparam int SW_TAG_W     = 7;
  localparam int SW_DATA_W    = 24;
  localparam int ERR_CNT_W    = 8;

  // Build a valid switch word from a tag and a stimulus payload.
  function automatic logic [31:0] sw_word(input logic [SW_TAG_W-1:0] tag,
                                          input logic [SW_DATA_W-1:0] data);
    return {1'b1, tag, data};
  endfunction

endpackage

// File: rtl/sw_stim_vec_mem.sv
// DEPTH x 24 stimulus storage: synchronous write, asynchronous read.
module sw_stim_vec_mem
  import sw_stim_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic [SW_DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]        i_raddr,
  output logic [SW_DATA_W-1:0] o_rdata
);

  logic [SW_DATA_W-1:0] mem_r [DEPTH];

  // Vector storage write port; contents intentionally survive reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_r[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_r[i_raddr];

endmodule

// File: rtl/sw_stimulus_driver.sv
// Feeds preloaded 24-bit stimulus words to the core's switch mailbox with a four-phase
// handshake on LEDR. Optional echo comparison: define SW_STIM_ECHO_CHECK_EN.
module sw_stimulus_driver
  import sw_stim_pkg::*;
#(
  parameter int          DEPTH         = 64,
  parameter int unsigned TIMEOUT_INSNS = 4096
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_ld_we,
  input  logic [$clog2(DEPTH)-1:0]     i_ld_addr,
  input  logic [SW_DATA_W-1:0]         i_ld_data,
  input  logic [$clog2(DEPTH):0]       i_num_vec,
  input  logic                         i_start,
  input  logic                         i_insn_vld,
  input  logic [31:0]                  i_io_ledr,
  output logic [31:0]                  o_io_sw,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_timeout,
  output logic [$clog2(DEPTH)-1:0]     o_vec_idx,
  output logic [ERR_CNT_W-1:0]         o_err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam logic [AW-1:0] IDX_ONE = AW'(32'd1);
  localparam logic [NW-1:0] NUM_ONE = NW'(32'd1);

  sw_stim_state_e       state_r;
  logic [31:0]          sw_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 timeout_r;
  logic [AW-1:0]        idx_r;
  logic [NW-1:0]        num_vec_r;
  logic [31:0]          tmo_cnt_r;
  logic [ERR_CNT_W-1:0] err_r;

  logic [AW-1:0]        rd_addr_s;
  logic [SW_DATA_W-1:0] rd_data_s;
  logic [SW_DATA_W-1:0] start_data_s;
  logic                 mem_we_s;
  logic                 ack_s;
  logic                 last_s;
  logic                 tmo_hit_s;
  logic                 start_take_s;

  function automatic logic [SW_TAG_W-1:0] tag_of(input logic [AW-1:0] idx);
    return SW_TAG_W'(idx);
  endfunction

  assign mem_we_s     = i_ld_we && !busy_r;
  assign start_take_s = i_start && !busy_r;

  sw_stim_vec_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_vec_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we_s),
    .i_waddr (i_ld_addr),
    .i_wdata (i_ld_data),
    .i_raddr (rd_addr_s),
    .o_rdata (rd_data_s)
  );

  // Read the entry about to be presented: current in PRESENT, next in RELEASE.
  always_comb begin
    rd_addr_s = '0;
    case (state_r)
      ST_PRESENT: rd_addr_s = idx_r;
      ST_RELEASE: rd_addr_s = idx_r + IDX_ONE;
      default:    rd_addr_s = '0;
    endcase
  end

  // A load to entry 0 in the start cycle must be visible in the first presented word.
  assign start_data_s = (i_ld_we && (i_ld_addr == '0)) ? i_ld_data : rd_data_s;

  assign ack_s = i_io_ledr[SW_VALID_BIT] &&
                 (i_io_ledr[SW_TAG_MSB:SW_TAG_LSB] == tag_of(idx_r));
  assign last_s    = (({1'b0, idx_r} + NUM_ONE) == num_vec_r);
  assign tmo_hit_s = (TIMEOUT_INSNS != 32'd0) && i_insn_vld &&
                     ((tmo_cnt_r + 32'd1) == TIMEOUT_INSNS);

  // Handshake sequencer with registered outputs; progress beats timeout.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r   <= ST_IDLE;
      sw_r      <= 32'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      idx_r     <= '0;
      num_vec_r <= '0;
      tmo_cnt_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (i_start) begin
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            tmo_cnt_r <= 32'd0;
            idx_r     <= '0;
            num_vec_r <= i_num_vec;
            if (i_num_vec == '0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              sw_r    <= 32'd0;
            end else begin
              state_r <= ST_PRESENT;
              busy_r  <= 1'b1;
              sw_r    <= sw_word(tag_of('0), start_data_s);
            end
          end
        end
        ST_PRESENT: begin
          if (ack_s) begin
            state_r   <= ST_RELEASE;
            sw_r      <= 32'd0;
            tmo_cnt_r <= 32'd0;
          end else if (tmo_hit_s) begin
            state_r   <= ST_FAIL;
            sw_r      <= 32'd0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b1;
            tmo_cnt_r <= 32'd0;
          end else if (i_insn_vld) begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
          end
        end
        ST_RELEASE: begin
          if (!i_io_ledr[SW_VALID_BIT]) begin
            tmo_cnt_r <= 32'd0;
            if (last_s) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_PRESENT;
              idx_r   <= idx_r + IDX_ONE;
              sw_r    <= sw_word(tag_of(idx_r + IDX_ONE), rd_data_s);
            end
          end else if (tmo_hit_s) begin
            state_r   <= ST_FAIL;
            busy_r    <= 1'b0;
            timeout_r <= 1'b1;
            tmo_cnt_r <= 32'd0;
          end else if (i_insn_vld) begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          sw_r      <= 32'd0;
          busy_r    <= 1'b0;
          tmo_cnt_r <= 32'd0;
        end
      endcase
    end
  end

`ifdef SW_STIM_ECHO_CHECK_EN
  // Count accepted acks whose echo differs from the presented payload.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      err_r <= '0;
    end else if (start_take_s) begin
      err_r <= '0;
    end else if ((state_r == ST_PRESENT) && ack_s &&
                 (i_io_ledr[SW_DATA_W-1:0] != rd_data_s) && (err_r != 8'hFF)) begin
      err_r <= err_r + 8'd1;
    end
  end
`else
  logic unused_echo_s;
  assign unused_echo_s = ^{i_io_ledr[SW_DATA_W-1:0], start_take_s};
  assign err_r = '0;
`endif

  assign o_io_sw   = sw_r;
  assign o_busy    = busy_r;
  assign o_done    = done_r;
  assign o_timeout = timeout_r;
  assign o_vec_idx = idx_r;
  assign o_err_cnt = err_r;

endmodule
